// File: rtl/hazard_unit.sv
// Decode-side hazard detector: tracks EX/MEM destinations, registers ALU forwarding selects,
// stalls one cycle on load-use, and counts load-use stall cycles with saturation.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_rd_wen,
  input  logic              i_id_is_load,
  input  logic              i_flush,
  input  logic              i_mem_busy,
  output logic              o_stall,
  output logic              o_frwd_alu_op1,
  output logic              o_frwd_mem_op1,
  output logic              o_frwd_alu_op2,
  output logic              o_frwd_mem_op2,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t              state;
  logic [REG_AW-1:0]   ex_rd, mem_rd;
  logic                ex_wen, ex_load, mem_wen;

  logic src1_ok, src2_ok, ex_writes, mem_writes;
  logic hit_ex1, hit_ex2, hit_mem1, hit_mem2;
  logic lu, bubble;

  // An x0 destination never produces a value worth forwarding.
  assign ex_writes  = ex_wen  & (ex_rd  != '0);
  assign mem_writes = mem_wen & (mem_rd != '0);
  assign src1_ok    = i_id_valid & i_id_use_rs1 & (i_id_rs1 != '0);
  assign src2_ok    = i_id_valid & i_id_use_rs2 & (i_id_rs2 != '0);

  assign hit_ex1  = src1_ok & ex_writes  & (ex_rd  == i_id_rs1);
  assign hit_ex2  = src2_ok & ex_writes  & (ex_rd  == i_id_rs2);
  assign hit_mem1 = src1_ok & mem_writes & (mem_rd == i_id_rs1);
  assign hit_mem2 = src2_ok & mem_writes & (mem_rd == i_id_rs2);

  // After a load-use stall the load sits in MEM, so a retried decode can never re-trigger.
  assign lu      = (state == RUN) & ex_load & (hit_ex1 | hit_ex2) & ~i_mem_busy;
  assign o_stall = (lu & ~i_flush) | i_mem_busy;
  assign bubble  = i_flush | lu | ~i_id_valid;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= RUN;
      ex_rd          <= '0;
      ex_wen         <= 1'b0;
      ex_load        <= 1'b0;
      mem_rd         <= '0;
      mem_wen        <= 1'b0;
      o_frwd_alu_op1 <= 1'b0;
      o_frwd_mem_op1 <= 1'b0;
      o_frwd_alu_op2 <= 1'b0;
      o_frwd_mem_op2 <= 1'b0;
      o_stall_cnt    <= '0;
    end else if (!i_mem_busy) begin
      mem_rd  <= ex_rd;
      mem_wen <= ex_wen;

      if (bubble) begin
        ex_rd          <= '0;
        ex_wen         <= 1'b0;
        ex_load        <= 1'b0;
        o_frwd_alu_op1 <= 1'b0;
        o_frwd_mem_op1 <= 1'b0;
        o_frwd_alu_op2 <= 1'b0;
        o_frwd_mem_op2 <= 1'b0;
      end else begin
        ex_rd          <= i_id_rd;
        ex_wen         <= i_id_rd_wen;
        ex_load        <= i_id_is_load;
        o_frwd_alu_op1 <= hit_ex1;
        o_frwd_mem_op1 <= hit_mem1 & ~hit_ex1;
        o_frwd_alu_op2 <= hit_ex2;
        o_frwd_mem_op2 <= hit_mem2 & ~hit_ex2;
      end

      case (state)
        RUN:      state <= (lu && !i_flush) ? LU_STALL : RUN;
        LU_STALL: state <= RUN;
        default:  state <= RUN;
      endcase

      if (lu && !i_flush && (o_stall_cnt != {CNT_W{1'b1}}))
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, use1, use2, rd_wen, is_load, flush, mem_busy;
  logic [4:0]    rs1, rs2, rd;
  logic          stall, a1, m1, a2, m2;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
    .i_id_rd(rd), .i_id_rd_wen(rd_wen), .i_id_is_load(is_load),
    .i_flush(flush), .i_mem_busy(mem_busy), .o_stall(stall),
    .o_frwd_alu_op1(a1), .o_frwd_mem_op1(m1), .o_frwd_alu_op2(a2), .o_frwd_mem_op2(m2),
    .o_stall_cnt(cnt)
  );

  typedef struct packed {
    logic       valid, u1, u2, wen, ld;
    logic [4:0] rs1, rs2, rd;
  } inst_t;

  typedef struct {
    string      name;
    inst_t      ins;
    logic       rst_n, flush, busy, chk;
    logic [4:0] outs;  // {stall, a1, m1, a2, m2}
    int         cnt;
  } vec_t;

  typedef struct {
    string         name;
    logic [4:0]    outs;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic inst_t nop();
    return '0;
  endfunction
  function automatic inst_t addi(int d, int s);
    return '{valid:1, u1:1, u2:0, wen:1, ld:0, rs1:5'(s), rs2:5'd0, rd:5'(d)};
  endfunction
  function automatic inst_t alu(int d, int s1, int s2);
    return '{valid:1, u1:1, u2:1, wen:1, ld:0, rs1:5'(s1), rs2:5'(s2), rd:5'(d)};
  endfunction
  function automatic inst_t lw(int d, int s);
    return '{valid:1, u1:1, u2:0, wen:1, ld:1, rs1:5'(s), rs2:5'd0, rd:5'(d)};
  endfunction

  task automatic v(input string name, input inst_t ins, input logic r, input logic f,
                   input logic b, input logic chk, input logic [4:0] outs, input int c);
    vec_t x;
    x.name = name; x.ins = ins; x.rst_n = r; x.flush = f; x.busy = b;
    x.chk = chk; x.outs = outs; x.cnt = c;
    vecs.push_back(x);
  endtask

  task automatic check(input exp_t e);
    logic [4:0] got;
    got = {stall, a1, m1, a2, m2};
    n_vec++;
    if (got !== e.outs || cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s: got stall/a1/m1/a2/m2=%b cnt=%0d, expected %b cnt=%0d",
               e.name, got, cnt, e.outs, e.cnt);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, one expectation per checked cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Expected outputs are those visible during the cycle the row's inputs are applied.
    v("rst0",           nop(),        0, 0, 0, 0, 5'b00000, 0);
    v("reset_state",    nop(),        0, 0, 0, 1, 5'b00000, 0);
    v("addi_x5",        addi(5, 1),   1, 0, 0, 1, 5'b00000, 0);
    v("add_x6_x5_x5",   alu(6, 5, 5), 1, 0, 0, 1, 5'b00000, 0);
    v("fwd_alu_both",   nop(),        1, 0, 0, 1, 5'b01010, 0);
    v("addi_x5_x0",     addi(5, 0),   1, 0, 0, 1, 5'b00000, 0);
    v("nop_gap",        nop(),        1, 0, 0, 1, 5'b00000, 0);
    v("sub_x7_x1_x5",   alu(7, 1, 5), 1, 0, 0, 1, 5'b00000, 0);
    v("fwd_mem_op2",    nop(),        1, 0, 0, 1, 5'b00001, 0);
    v("lw_x5",          lw(5, 2),     1, 0, 0, 1, 5'b00000, 0);
    v("lu_stall",       alu(6, 5, 1), 1, 0, 0, 1, 5'b10000, 0);
    v("lu_retry",       alu(6, 5, 1), 1, 0, 0, 1, 5'b00000, 1);
    v("fwd_mem_op1",    nop(),        1, 0, 0, 1, 5'b00100, 1);
    v("addi_x5_c",      addi(5, 0),   1, 0, 0, 1, 5'b00000, 1);
    v("addi_x5_x5",     addi(5, 5),   1, 0, 0, 1, 5'b00000, 1);
    v("add_x6_x5_x0",   alu(6, 5, 0), 1, 0, 0, 1, 5'b01000, 1);
    v("youngest_wins",  nop(),        1, 0, 0, 1, 5'b01000, 1);
    v("addi_x0",        addi(0, 1),   1, 0, 0, 1, 5'b00000, 1);
    v("add_x6_x0_x0",   alu(6, 0, 0), 1, 0, 0, 1, 5'b00000, 1);
    v("x0_no_fwd",      nop(),        1, 0, 0, 1, 5'b00000, 1);
    v("lw_x0",          lw(0, 2),     1, 0, 0, 1, 5'b00000, 1);
    v("use_x0_no_stall",alu(6, 0, 0), 1, 0, 0, 1, 5'b00000, 1);
    v("lw_x5_flush",    lw(5, 2),     1, 0, 0, 1, 5'b00000, 1);
    v("flush_beats_lu", alu(6, 5, 1), 1, 1, 0, 1, 5'b00000, 1);
    v("after_flush",    addi(5, 0),   1, 0, 0, 1, 5'b00000, 1);
    v("add_x6_x5_x5_b", alu(6, 5, 5), 1, 0, 0, 1, 5'b00000, 1);
    v("busy0",          alu(7, 6, 1), 1, 0, 1, 1, 5'b11010, 1);
    v("busy1_hold",     alu(7, 6, 1), 1, 0, 1, 1, 5'b11010, 1);
    v("busy2_hold",     alu(7, 6, 1), 1, 0, 1, 1, 5'b11010, 1);
    v("busy_release",   alu(7, 6, 1), 1, 0, 0, 1, 5'b01010, 1);
    v("post_busy",      nop(),        1, 0, 0, 1, 5'b01000, 1);
    for (int k = 0; k < 7; k++) begin
      v($sformatf("sat_lw_%0d", k),    lw(5, 2),     1, 0, 0, 1,
        (k > 0) ? 5'b00100 : 5'b00000, (1 + k > 7) ? 7 : 1 + k);
      v($sformatf("sat_stall_%0d", k), alu(6, 5, 1), 1, 0, 0, 1, 5'b10000,
        (1 + k > 7) ? 7 : 1 + k);
      v($sformatf("sat_retry_%0d", k), alu(6, 5, 1), 1, 0, 0, 1, 5'b00000,
        (2 + k > 7) ? 7 : 2 + k);
    end
    v("mid_lw",         lw(5, 2),     1, 0, 0, 1, 5'b00100, 7);
    v("mid_stall_sat",  alu(6, 5, 1), 1, 0, 0, 1, 5'b10000, 7);
    v("mid_reset",      alu(6, 5, 1), 0, 0, 0, 1, 5'b00000, 7);
    v("after_reset",    alu(6, 5, 1), 1, 0, 0, 1, 5'b00000, 0);
    v("after_reset_2",  nop(),        1, 0, 0, 1, 5'b00000, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n    = vecs[i].rst_n;
      flush    = vecs[i].flush;
      mem_busy = vecs[i].busy;
      id_valid = vecs[i].ins.valid;
      use1     = vecs[i].ins.u1;
      use2     = vecs[i].ins.u2;
      rd_wen   = vecs[i].ins.wen;
      is_load  = vecs[i].ins.ld;
      rs1      = vecs[i].ins.rs1;
      rs2      = vecs[i].ins.rs2;
      rd       = vecs[i].ins.rd;
      if (vecs[i].chk) begin
        exp_t e;
        e.name = vecs[i].name;
        e.outs = vecs[i].outs;
        e.cnt  = CW'(vecs[i].cnt);
        exp_q.push_back(e);
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
